// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: field widths, the word type and the
// combinational immediate extension used by both the ALU and branch paths.
package mips_pkg;

    localparam int IMM_WIDTH  = 16;
    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    // Unregistered extension so the branch-offset path can reuse it directly.
    function automatic word_t signExtendImm(input logic [IMM_WIDTH-1:0] imm);
        return {{(WORD_WIDTH - IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

endpackage

// File: rtl/sign_extend.sv
// Registered two's-complement sign extender that widens an I-type immediate
// to the datapath width, aligned with the other stage registers.
module sign_extend
    import mips_pkg::*;
#(
    parameter int IN_WIDTH   = IMM_WIDTH,
    parameter int OUT_WIDTH  = WORD_WIDTH,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  DataIn,
    output logic [OUT_WIDTH-1:0] DataOut
);

    logic [OUT_WIDTH-1:0] extended;

    if (IN_WIDTH < 1 || OUT_WIDTH < IN_WIDTH) begin : genBadWidths
        $error("sign_extend: need IN_WIDTH >= 1 and OUT_WIDTH >= IN_WIDTH");
    end

    // Equal widths would make the replication count zero, so pass straight through.
    if (OUT_WIDTH == IN_WIDTH) begin : genPassThrough
        assign extended = DataIn;
    end else if (IN_WIDTH == IMM_WIDTH && OUT_WIDTH == WORD_WIDTH) begin : genPkgExtend
        assign extended = signExtendImm(DataIn);
    end else begin : genReplicate
        assign extended = {{(OUT_WIDTH - IN_WIDTH){DataIn[IN_WIDTH-1]}}, DataIn};
    end

    if (REGISTERED) begin : genFlopped
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                DataOut <= '0;
            end else begin
                DataOut <= extended;
            end
        end
    end else begin : genComb
        assign DataOut = extended;
    end

endmodule

// File: tb/tb_sign_extend.sv
// Directed and random checks of the registered sign extender.
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] DataIn;
    logic [31:0] DataOut;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] boundIn  [6] = '{16'h0003, 16'hFFFD, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    logic [31:0] boundExp [6] = '{32'h00000003, 32'hFFFFFFFD, 32'h00007FFF,
                                  32'hFFFF8000, 32'h00000000, 32'hFFFFFFFF};

    sign_extend dut (
        .clk     (clk),
        .rst     (rst),
        .DataIn  (DataIn),
        .DataOut (DataOut)
    );

    always #10 clk = ~clk;

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (DataOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_before_edge: got %h, want 00000000", DataOut);
        end
        stepEdge();
        compared++;
        if (DataOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got %h, want 00000000", DataOut);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_positive();
        @(negedge clk);
        DataIn = 16'h0003;
        stepEdge();
        compared++;
        if (DataOut !== 32'h00000003) begin
            mismatched++;
            $display("[TB] FAIL positive: got %h, want 00000003", DataOut);
        end
    endtask

    task automatic test_negative();
        @(negedge clk);
        DataIn = 16'hFFFD;
        stepEdge();
        compared++;
        if (DataOut !== 32'hFFFFFFFD) begin
            mismatched++;
            $display("[TB] FAIL negative: got %h, want FFFFFFFD", DataOut);
        end
    endtask

    task automatic test_boundaries();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            DataIn = boundIn[i];
            stepEdge();
            compared++;
            if (DataOut !== boundExp[i]) begin
                mismatched++;
                $display("[TB] FAIL boundary_%h: got %h, want %h", boundIn[i], DataOut, boundExp[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        DataIn = 16'h0003;
        stepEdge();
        @(negedge clk);
        DataIn = 16'h8000;
        #1;
        compared++;
        if (DataOut !== 32'h00000003) begin
            mismatched++;
            $display("[TB] FAIL latency_hold: got %h, want 00000003", DataOut);
        end
        stepEdge();
        compared++;
        if (DataOut !== 32'hFFFF8000) begin
            mismatched++;
            $display("[TB] FAIL latency_update: got %h, want FFFF8000", DataOut);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        DataIn = 16'hFFFD;
        stepEdge();
        compared++;
        if (DataOut !== 32'hFFFFFFFD) begin
            mismatched++;
            $display("[TB] FAIL areset_preload: got %h, want FFFFFFFD", DataOut);
        end
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        compared++;
        if (DataOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL areset_immediate: got %h, want 00000000", DataOut);
        end
        DataIn = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            stepEdge();
            compared++;
            if (DataOut !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL areset_held_%0d: got %h, want 00000000", i, DataOut);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (DataOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL areset_release_noedge: got %h, want 00000000", DataOut);
        end
        stepEdge();
        compared++;
        if (DataOut !== 32'h00001234) begin
            mismatched++;
            $display("[TB] FAIL areset_first_capture: got %h, want 00001234", DataOut);
        end
    endtask

    task automatic test_random();
        logic [15:0] val;
        logic [31:0] expVal;
        int          signedVal;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            val       = 16'($urandom);
            DataIn    = val;
            signedVal = $signed(val);
            expVal    = signedVal;
            stepEdge();
            compared++;
            if (DataOut !== expVal) begin
                mismatched++;
                $display("[TB] FAIL random_%0d in=%h: got %h, want %h", i, val, DataOut, expVal);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        DataIn = 16'h0000;
        test_reset();
        test_positive();
        test_negative();
        test_boundaries();
        test_latency();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
